// File: rtl/uc_multiciclo_if.sv
// Bus between the multicycle control unit and the IR/PC/datapath side.
// master: datapath/IR side; slave: control unit.
interface uc_multiciclo_if #(
    parameter int unsigned DS_DEPTH = 16,
    parameter int unsigned RS_DEPTH = 16
);
    localparam int unsigned DS_W = $clog2(DS_DEPTH + 1);
    localparam int unsigned RS_W = $clog2(RS_DEPTH + 1);

    logic [5:0]      opcode;
    logic            z;
    logic [16:0]     ctrl;
    logic [2:0]      op_alu;
    logic            ir_we;
    logic            pc_we;
    logic [DS_W-1:0] ds_count;
    logic [RS_W-1:0] rs_count;
    logic            fault;
    logic [2:0]      fault_code;

    modport master (
        output opcode, z,
        input  ctrl, op_alu, ir_we, pc_we, ds_count, rs_count, fault, fault_code
    );

    modport slave (
        input  opcode, z,
        output ctrl, op_alu, ir_we, pc_we, ds_count, rs_count, fault, fault_code
    );
endinterface

// File: rtl/uc_multiciclo.sv
// Multicycle control unit: FETCH -> EXEC -> (MEMW x MEM_LAT) -> FETCH, sticky FAULT.
// Define UC_STACK_CHECK_EN to enable stack depth tracking and fault detection.
module uc_multiciclo #(
    parameter int unsigned DS_DEPTH = 16,
    parameter int unsigned RS_DEPTH = 16,
    parameter int unsigned MEM_LAT  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    uc_multiciclo_if.slave bus
);
    localparam int unsigned DS_W = $clog2(DS_DEPTH + 1);
    localparam int unsigned RS_W = $clog2(RS_DEPTH + 1);

    localparam logic [16:0] C_WE3   = 17'h10000;
    localparam logic [16:0] C_WEZ   = 17'h08000;
    localparam logic [16:0] C_SINC  = 17'h04000;
    localparam logic [16:0] C_SALTO = 17'h02000;
    localparam logic [16:0] C_REGS  = 17'h01000;
    localparam logic [16:0] C_GUARD = 17'h00800;
    localparam logic [16:0] C_AMEM  = 17'h00400;
    localparam logic [16:0] C_SDIR  = 17'h00200;
    localparam logic [16:0] C_ARS   = 17'h00100;
    localparam logic [16:0] C_PRS   = 17'h00080;
    localparam logic [16:0] C_SRS   = 17'h00040;
    localparam logic [16:0] C_APD   = 17'h00020;
    localparam logic [16:0] C_PPD   = 17'h00010;
    localparam logic [16:0] C_SPD   = 17'h00008;
    localparam logic [16:0] C_SAM   = 17'h00004;
    localparam logic [16:0] C_EDL   = 17'h00002;
    localparam logic [16:0] C_EDH   = 17'h00001;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEMW, S_FAULT} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_wait;
    logic [16:0] w_dec, w_fin, w_ctrl;
    logic        w_is_load, w_is_store, w_mem, w_trip;
    logic        w_ir_we, w_pc_we;
    logic [2:0]  w_op_alu;

    // w_dec holds the strobes common to every cycle of the instruction; the
    // load/store write strobe (w_fin) is added only on the completing cycle.
    always_comb begin
        w_dec      = '0;
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        casez (bus.opcode)
            6'b0?????: w_dec = C_WE3 | C_WEZ | C_SINC;
            6'b1000??: w_dec = C_WE3 | C_SINC | C_REGS;
            6'b1001??: w_dec = C_SINC | C_APD | C_PPD | C_SPD;
            6'b1010??: w_dec = C_WE3 | C_SINC | C_APD | C_SPD;
            6'b1011??: begin
                w_dec     = C_AMEM | C_SDIR | C_SAM | C_SINC;
                w_is_load = 1'b1;
            end
            6'b1100??: begin
                w_dec      = C_AMEM | C_SAM | C_SINC;
                w_is_store = 1'b1;
            end
            6'b1101??: w_dec = C_SINC;
            6'b111000: w_dec = C_EDH | C_SINC;
            6'b111001: w_dec = C_EDL | C_SINC;
            6'b111010: w_dec = C_SALTO | C_ARS | C_SRS;
            6'b111011: w_dec = C_ARS | C_PRS;
            6'b111100: w_dec = '0;
            6'b111101: w_dec = bus.z ? C_SINC : '0;
            6'b111110: w_dec = bus.z ? '0 : C_SINC;
            6'b111111: w_dec = C_SINC | C_SALTO;
            default:   w_dec = '0;
        endcase
    end

    assign w_mem = w_is_load | w_is_store;
    assign w_fin = (w_is_load ? C_WE3 : '0) | (w_is_store ? C_GUARD : '0);

    always_comb begin
        w_next   = r_state;
        w_ctrl   = '0;
        w_ir_we  = 1'b0;
        w_pc_we  = 1'b0;
        w_op_alu = bus.opcode[4:2];
        case (r_state)
            S_FETCH: begin
                w_ir_we = 1'b1;
                w_next  = S_EXEC;
            end
            S_EXEC: begin
                if (w_trip) begin
                    w_next = S_FAULT;
                end else if (w_mem && MEM_LAT != 0) begin
                    w_ctrl = w_dec;
                    w_next = S_MEMW;
                end else begin
                    w_ctrl  = w_dec | w_fin;
                    w_pc_we = 1'b1;
                    w_next  = S_FETCH;
                end
            end
            S_MEMW: begin
                w_ctrl = w_dec;
                if (r_wait == 4'(MEM_LAT - 1)) begin
                    w_ctrl  = w_dec | w_fin;
                    w_pc_we = 1'b1;
                    w_next  = S_FETCH;
                end
            end
            S_FAULT: w_op_alu = '0;
            default: w_next = S_FETCH;
        endcase
        // Gate everything during reset: FETCH would otherwise drive ir_we.
        if (!rst_n) begin
            w_ctrl   = '0;
            w_ir_we  = 1'b0;
            w_pc_we  = 1'b0;
            w_op_alu = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_EXEC && w_next == S_MEMW)
                r_wait <= '0;
            else if (r_state == S_MEMW)
                r_wait <= r_wait + 4'd1;
        end
    end

    assign bus.ctrl   = w_ctrl;
    assign bus.ir_we  = w_ir_we;
    assign bus.pc_we  = w_pc_we;
    assign bus.op_alu = w_op_alu;

`ifdef UC_STACK_CHECK_EN
    logic [DS_W-1:0] r_ds;
    logic [RS_W-1:0] r_rs;
    logic [2:0]      r_fcode, w_fcode;
    logic            w_ds_inc, w_ds_dec, w_rs_inc, w_rs_dec, w_commit;

    always_comb begin
        w_ds_inc = (bus.opcode[5:2] == 4'b1001);
        w_ds_dec = (bus.opcode[5:2] == 4'b1010);
        w_rs_inc = (bus.opcode == 6'b111011);
        w_rs_dec = (bus.opcode == 6'b111010);
        w_fcode  = 3'd0;
        if (w_ds_inc && r_ds == DS_W'(DS_DEPTH))      w_fcode = 3'd1;
        else if (w_ds_dec && r_ds == '0)              w_fcode = 3'd2;
        else if (w_rs_inc && r_rs == RS_W'(RS_DEPTH)) w_fcode = 3'd3;
        else if (w_rs_dec && r_rs == '0)              w_fcode = 3'd4;
        else if (bus.opcode[5:2] == 4'b1101)          w_fcode = 3'd5;
        w_trip = (w_fcode != 3'd0);
    end

    assign w_commit = (r_state == S_EXEC) && !w_trip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ds    <= '0;
            r_rs    <= '0;
            r_fcode <= '0;
        end else begin
            if (w_commit) begin
                if (w_ds_inc)      r_ds <= r_ds + 1'b1;
                else if (w_ds_dec) r_ds <= r_ds - 1'b1;
                if (w_rs_inc)      r_rs <= r_rs + 1'b1;
                else if (w_rs_dec) r_rs <= r_rs - 1'b1;
            end
            if (r_state == S_EXEC && w_trip)
                r_fcode <= w_fcode;
        end
    end

    assign bus.ds_count   = r_ds;
    assign bus.rs_count   = r_rs;
    assign bus.fault      = (r_state == S_FAULT);
    assign bus.fault_code = r_fcode;
`else
    assign w_trip         = 1'b0;
    assign bus.ds_count   = '0;
    assign bus.rs_count   = '0;
    assign bus.fault      = 1'b0;
    assign bus.fault_code = '0;
`endif
endmodule

// File: tb/tb_uc_multiciclo.sv
// Randomised self-checking bench for uc_multiciclo (DS/RS depth 2, MEM_LAT 3)
// against an instruction-level reference model; honours UC_STACK_CHECK_EN.
module tb_uc_multiciclo;
    localparam int unsigned DSD = 2;
    localparam int unsigned RSD = 2;
    localparam int unsigned LAT = 3;
`ifdef UC_STACK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uc_multiciclo_if #(.DS_DEPTH(DSD), .RS_DEPTH(RSD)) bus ();

    uc_multiciclo #(.DS_DEPTH(DSD), .RS_DEPTH(RSD), .MEM_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int m_ds, m_rs, m_code;
    bit m_faulted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobes of a completing cycle, straight from the opcode table.
    function automatic logic [16:0] exp_full(input logic [5:0] op, input logic zv);
        logic we3, wez, sinc, salto, regs, guard, amem, sdir;
        logic ars, prs, srs, apd, ppd, spd, sam, edl, edh;
        {we3, wez, sinc, salto, regs, guard, amem, sdir} = '0;
        {ars, prs, srs, apd, ppd, spd, sam, edl, edh}    = '0;
        if (!op[5]) begin
            we3 = 1; wez = 1; sinc = 1;
        end else begin
            case (op[4:2])
                3'd0: begin we3 = 1; sinc = 1; regs = 1; end
                3'd1: begin sinc = 1; apd = 1; ppd = 1; spd = 1; end
                3'd2: begin we3 = 1; sinc = 1; apd = 1; spd = 1; end
                3'd3: begin amem = 1; sdir = 1; sam = 1; sinc = 1; we3 = 1; end
                3'd4: begin amem = 1; guard = 1; sam = 1; sinc = 1; end
                3'd5: sinc = 1;
                3'd6: case (op[1:0])
                    2'd0: begin edh = 1; sinc = 1; end
                    2'd1: begin edl = 1; sinc = 1; end
                    2'd2: begin salto = 1; ars = 1; srs = 1; end
                    default: begin ars = 1; prs = 1; end
                endcase
                default: case (op[1:0])
                    2'd0: sinc = 0;
                    2'd1: sinc = zv;
                    2'd2: sinc = ~zv;
                    default: begin sinc = 1; salto = 1; end
                endcase
            endcase
        end
        return {we3, wez, sinc, salto, regs, guard, amem, sdir,
                ars, prs, srs, apd, ppd, spd, sam, edl, edh};
    endfunction

    task automatic check_state(input string where);
        check({where, ".ds_count"},   bus.ds_count,   CHK ? m_ds : 0);
        check({where, ".rs_count"},   bus.rs_count,   CHK ? m_rs : 0);
        check({where, ".fault"},      bus.fault,      m_faulted);
        check({where, ".fault_code"}, bus.fault_code, m_code);
    endtask

    // Entered just after a rising edge with the DUT in FETCH (or FAULT);
    // leaves at the same point of the next instruction.
    task automatic run_instr(input logic [5:0] op, input logic zv);
        int          code, n_exec;
        logic [16:0] full, part;
        bit          mem;
        string       t;
        bus.opcode = op;
        bus.z      = zv;
        t = $sformatf("op%02h", op);
        @(negedge clk);
        if (m_faulted) begin
            check({t, ".fault_ctrl"},  bus.ctrl,  17'h0);
            check({t, ".fault_irwe"},  bus.ir_we, 1'b0);
            check({t, ".fault_pcwe"},  bus.pc_we, 1'b0);
        end else begin
            check({t, ".fetch_irwe"}, bus.ir_we,  1'b1);
            check({t, ".fetch_ctrl"}, bus.ctrl,   17'h0);
            check({t, ".fetch_pcwe"}, bus.pc_we,  1'b0);
            check({t, ".op_alu"},     bus.op_alu, op[4:2]);
            code = 0;
            if (op[5:2] == 4'b1001 && m_ds == DSD)      code = 1;
            else if (op[5:2] == 4'b1010 && m_ds == 0)   code = 2;
            else if (op == 6'b111011 && m_rs == RSD)    code = 3;
            else if (op == 6'b111010 && m_rs == 0)      code = 4;
            else if (op[5:2] == 4'b1101)                code = 5;
            if (!CHK) code = 0;
            full   = exp_full(op, zv);
            part   = full & ~17'h10800;
            mem    = (op[5:2] == 4'b1011) || (op[5:2] == 4'b1100);
            n_exec = (code == 0 && mem) ? 1 + LAT : 1;
            for (int c = 1; c <= n_exec; c++) begin
                bit last;
                last = (c == n_exec);
                @(posedge clk);
                @(negedge clk);
                check($sformatf("%s.c%0d.ctrl", t, c), bus.ctrl,
                      code != 0 ? 17'h0 : (last ? full : part));
                check($sformatf("%s.c%0d.pc_we", t, c), bus.pc_we, code == 0 && last);
                check($sformatf("%s.c%0d.ir_we", t, c), bus.ir_we, 1'b0);
            end
            if (code != 0) begin
                m_faulted = 1;
                m_code    = code;
            end else begin
                if (op[5:2] == 4'b1001) m_ds++;
                if (op[5:2] == 4'b1010) m_ds--;
                if (op == 6'b111011)    m_rs++;
                if (op == 6'b111010)    m_rs--;
            end
        end
        @(posedge clk);
        #1;
        check_state(t);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        bus.opcode = 6'($urandom_range(1, 63));
        bus.z      = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("rst.ctrl",   bus.ctrl,   17'h0);
        check("rst.ir_we",  bus.ir_we,  1'b0);
        check("rst.pc_we",  bus.pc_we,  1'b0);
        check("rst.op_alu", bus.op_alu, 3'd0);
        check("rst.ds",     bus.ds_count, 0);
        check("rst.rs",     bus.rs_count, 0);
        check("rst.fault",  bus.fault,    1'b0);
        check("rst.code",   bus.fault_code, 3'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        m_ds      = 0;
        m_rs      = 0;
        m_code    = 0;
        m_faulted = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        bus.opcode = '0;
        bus.z      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        run_instr(6'b000100, 1'b0);
        run_instr(6'b101100, 1'b0);
        run_instr(6'b110010, 1'b1);
        run_instr(6'b111101, 1'b1);
        run_instr(6'b111101, 1'b0);
        run_instr(6'b111110, 1'b1);
        run_instr(6'b111110, 1'b0);
        run_instr(6'b111100, 1'b1);
        run_instr(6'b111111, 1'b0);
        run_instr(6'b111000, 1'b0);
        run_instr(6'b111001, 1'b0);
        run_instr(6'b100011, 1'b0);
        run_instr(6'b100100, 1'b0);
        run_instr(6'b100101, 1'b0);
        run_instr(6'b100110, 1'b0);
        run_instr(6'b000000, 1'b0);
        do_reset();
        run_instr(6'b111010, 1'b0);
        run_instr(6'b000001, 1'b0);
        do_reset();
        run_instr(6'b111011, 1'b0);
        run_instr(6'b111011, 1'b0);
        run_instr(6'b111011, 1'b0);
        do_reset();
        run_instr(6'b110101, 1'b0);
        run_instr(6'b101000, 1'b0);
        do_reset();

        // Reset asserted in the middle of a load must abort it outright.
        bus.opcode = 6'b101101;
        @(negedge clk);
        check("abort.fetch", bus.ir_we, 1'b1);
        @(posedge clk);
        #1;
        check("abort.exec_amem", bus.ctrl, 17'h04604);
        do_reset();
        run_instr(6'b010111, 1'b1);

        for (int i = 0; i < 400; i++) begin
            logic [5:0] op;
            if (i % 12 == 0) do_reset();
            case ($urandom_range(0, 3))
                0: op = 6'($urandom_range(36, 43));
                1: op = 6'($urandom_range(58, 59));
                default: op = 6'($urandom_range(0, 63));
            endcase
            run_instr(op, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uc_multiciclo.md
# uc_multiciclo

Multicycle, parametrised successor to the processor's control unit. It sequences every instruction through fetch, execute and optional data-memory wait states instead of decoding in a single cycle. It drives the same datapath control strobes and adds a PC write strobe, instruction-register load, depth tracking for the data and subroutine stacks, and a sticky fault state. It sits between the instruction register/PC and the datapath.

## Interface
- DS_DEPTH, 16: data-stack capacity in entries (≥1).
- RS_DEPTH, 16: subroutine-stack capacity in entries (≥1).
- MEM_LAT, 1: extra wait cycles per data-memory load/store (0..15).

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  opcode field of the instruction register; stable from the cycle after ir_we until the next ir_we.
- z  in  1  zero flag, sampled in EXEC.
- ctrl  out  17  packed strobes, bit16..0: we3, wez, s_inc, selectorMuxSaltoR, selectorMuxRegistros, guardarMemoriaDatos, activarMemoriaDatos, selectorMuxDireccionesMemoriaDatos, activarPilaSubR, pushPilaSubR, selectorMuxPilaSubR, activarPilaDatos, pushPilaDatos, selectorMuxPilaDatos, selectorMuxAluMem_E_S, editdirles, editdirhig.
- op_alu  out  3  opcode[4:2] in every state.
- ir_we  out  1  instruction-register load strobe.
- pc_we  out  1  PC update strobe; s_inc and selectorMuxSaltoR select the next PC when it is high.
- ds_count  out  $clog2(DS_DEPTH+1)  data-stack occupancy.
- rs_count  out  $clog2(RS_DEPTH+1)  subroutine-stack occupancy.
- fault  out  1  sticky fault flag.
- fault_code  out  3  0 none, 1 DS overflow, 2 DS underflow, 3 RS overflow, 4 RS underflow, 5 reserved opcode.

## Operation
- States: FETCH, EXEC, MEMW, FAULT. Reset enters FETCH with all counters, fault and fault_code at 0. While rst_n is low, all outputs are 0.
- FETCH: ir_we=1, ctrl=0, pc_we=0. Next state is EXEC.
- EXEC decode: ctrl carries the instruction's encoding; pc_we=1 unless the instruction goes to MEMW or faults. Next state is FETCH.
  - 0xxxxx ALU: we3, wez, s_inc.
  - 1000xx load immediate: we3, s_inc, selectorMuxRegistros.
  - 1001xx push: s_inc, activarPilaDatos, pushPilaDatos, selectorMuxPilaDatos. ds_count+1.
  - 1010xx pop: we3, s_inc, activarPilaDatos, selectorMuxPilaDatos. ds_count−1.
  - 1011xx load: activarMemoriaDatos, selectorMuxDireccionesMemoriaDatos, selectorMuxAluMem_E_S, s_inc.
  - 1100xx store: activarMemoriaDatos, guardarMemoriaDatos, selectorMuxAluMem_E_S, s_inc.
  - 1101xx reserved: NOP (s_inc, pc_we only).
  - 111000 editdirhig; 111001 editdirles. Both with s_inc.
  - 111010 return: selectorMuxSaltoR, activarPilaSubR, selectorMuxPilaSubR, s_inc=0. rs_count−1.
  - 111011 call: activarPilaSubR, pushPilaSubR, s_inc=0. rs_count+1.
  - 111100 J: s_inc=0.
  - 111101 JZ: s_inc = z.
  - 111110 JNZ: s_inc = ~z.
  - 111111 JR: s_inc=1, selectorMuxSaltoR=1.
- Load/store with MEM_LAT>0: EXEC holds the address/enable/select strobes with we3=0, guardarMemoriaDatos=0 and pc_we=0, then moves to MEMW.
  - MEMW keeps the same strobes for MEM_LAT cycles.
  - we3 (load) or guardarMemoriaDatos (store), plus pc_we, assert only in the last MEMW cycle. The next state after that cycle is FETCH.
  - With MEM_LAT=0, the instruction completes in EXEC.
- Stack counters change only on a committing EXEC cycle. At most one counter moves per instruction.
- FAULT: entered from EXEC when a check trips. In the faulting cycle, ctrl write/push strobes are 0, pc_we=0 and counters are held. FAULT keeps all outputs 0 except fault=1 and fault_code. It exits only via rst_n.

## Timing
- Cycles per instruction: 2 for non-memory instructions; 2+MEM_LAT for load/store.
- ctrl and pc_we are combinational from state and opcode. Counters, state, fault and fault_code are registered.
- Reset asserted mid-instruction aborts immediately. No partial strobe survives the deassertion, and the first cycle after deassertion is FETCH.

## Configuration
- UC_STACK_CHECK_EN defined:
  - push with ds_count==DS_DEPTH faults with code 1; pop with ds_count==0 faults with code 2.
  - call with rs_count==RS_DEPTH faults with code 3; return with rs_count==0 faults with code 4.
  - 1101xx faults with code 5.
- Undefined:
  - counters and FAULT logic are absent; ds_count, rs_count, fault and fault_code are tied to 0.
  - 1101xx is a NOP and stack operations are never blocked.

## Test plan
- Reset then ALU opcode 000100: FETCH ir_we=1; next cycle ctrl has we3=wez=s_inc=1, op_alu=001, pc_we=1.
- Load 101100 with MEM_LAT=3: activarMemoriaDatos high for 4 cycles; we3 and pc_we high only in cycle 4 after FETCH.
- JZ with z=1 → s_inc=1. JZ with z=0 → s_inc=0. JNZ with z=1 → s_inc=0. pc_we=1 in all cases.
- DS_DEPTH=2, check on: push, push, push → ds_count=2, third push gives fault=1, code 1, pushPilaDatos=0. Check off: no fault.
- Return with rs_count=0, check on → fault code 4. rst_n pulse low → FETCH, fault=0, counts=0.
- Opcode 110101, check on → fault code 5; check off → NOP, pc_we=1, s_inc=1.
